bs_out_wb_stream: RTL and testbench

- AXI-Stream transmitter that drains the bit-serial LUT output buffers to DMA, as the counterpart of the core's act/wgt AXIS receivers.
- Issues write-back read requests (group select, per-column address, bank select) into the LUT core.
- Captures the registered 64-bit `bs_out_wb_data` a fixed latency later and presents it on `m_axis` with full tready backpressure.
- Sits between the LUT core and the output DMA, started by the layer controller.

---
 rtl/bs_wb_pkg.sv | 28 ++
 rtl/bs_wb_fifo.sv | 55 +++++
 rtl/bs_out_wb_stream.sv | 192 +++++++++++++++++++
 tb/tb_bs_out_wb_stream.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_wb_pkg.sv
// Shared types and constants for the bit-serial output write-back streamer.
package bs_wb_pkg;

  localparam int BS_COLS_DEF          = 32;
  localparam int BS_OUT_BUF_DEPTH_DEF = 9;
  localparam int NUM_GRP              = BS_COLS_DEF / 8;
  localparam int RD_LAT               = 2;
  localparam int FIFO_DEPTH_DEF       = 4;
  localparam int BEAT_W               = 64;

  typedef struct packed {
    logic              last;
    logic [BEAT_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wb_state_e;

  // Core group-select encoding: 0 means no read, otherwise group index + 1.
  function automatic logic [2:0] grp_to_en(input logic [2:0] grp);
    return grp + 3'd1;
  endfunction

endpackage

// File: rtl/bs_wb_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; rdata is the head entry
// whenever empty is low.
module bs_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && (count_q != CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/bs_out_wb_stream.sv
// Drains the LUT core's bit-serial output buffers onto an AXI-Stream master.
// Define BS_WB_PERF_EN to build the saturating backpressure counter wb_stall_cnt.
//
// state | meaning
// IDLE  | waiting for start; zero-length start only pulses done
// ISSUE | one read request per cycle while FIFO credit allows
// DRAIN | all requests issued; waiting for the last beat to handshake
// DONE  | one-cycle done pulse, then back to IDLE
module bs_out_wb_stream
  import bs_wb_pkg::*;
#(
  parameter int BS_COLS          = BS_COLS_DEF,
  parameter int BS_OUT_BUF_DEPTH = BS_OUT_BUF_DEPTH_DEF,
  parameter int FIFO_DEPTH       = FIFO_DEPTH_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [BS_OUT_BUF_DEPTH:0]           num_addr,
  input  logic                                buf_sel,
  output logic                                busy,
  output logic                                done,
  output logic [2:0]                          bs_out_buf_wb_en,
  output logic [BS_COLS*BS_OUT_BUF_DEPTH-1:0] bs_out_buf_wb_addr,
  output logic                                bs_out_buf_wb_sel,
  input  logic [63:0]                         bs_out_wb_data,
  output logic [63:0]                         m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic [31:0]                         wb_stall_cnt
);

  localparam int GRP_N = BS_COLS / 8;
  localparam int AW    = BS_OUT_BUF_DEPTH;
  localparam int NW    = BS_OUT_BUF_DEPTH + 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  wb_state_e         state_q, state_d;
  logic [NW-1:0]     rem_q;
  logic [AW-1:0]     addr_cnt_q, req_addr_q;
  logic [2:0]        grp_cnt_q, en_q;
  logic              sel_q, req_vld_q, req_last_q, zero_done_q;
  logic [RD_LAT-1:0] tag_vld_q, tag_last_q;

  logic              start_ok, start_run, grp_last, last_req, credit, issue, last_pop;
  logic [CW:0]       inflight_cnt, occupancy;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_push, fifo_pop;
  wb_entry_t         fifo_wdata, fifo_rdata;

  assign start_ok  = start && (state_q == IDLE);
  assign start_run = start_ok && (num_addr != '0);
  assign grp_last  = (grp_cnt_q == 3'(GRP_N - 1));
  // rem_q counts addresses still to be requested, so 1 marks the final address.
  assign last_req  = (rem_q == NW'(1)) && grp_last;

  // The request register is counted too: its data lands in the FIFO RD_LAT+1 edges later.
  always_comb begin
    inflight_cnt = {{CW{1'b0}}, req_vld_q};
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + {{CW{1'b0}}, tag_vld_q[i]};
    end
  end

  assign occupancy = {1'b0, fifo_count} + inflight_cnt;
  assign credit    = (occupancy < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_run) state_d = ISSUE;
      ISSUE:   if (issue && last_req) state_d = DRAIN;
      DRAIN:   if (last_pop && (inflight_cnt == '0) && (fifo_count == CW'(1))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = zero_done_q;
    issue = 1'b0;
    case (state_q)
      ISSUE: begin
        busy  = 1'b1;
        issue = credit;
      end
      DRAIN: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q       <= '0;
      addr_cnt_q  <= '0;
      grp_cnt_q   <= '0;
      sel_q       <= 1'b0;
      req_vld_q   <= 1'b0;
      req_last_q  <= 1'b0;
      req_addr_q  <= '0;
      en_q        <= '0;
      tag_vld_q   <= '0;
      tag_last_q  <= '0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= start_ok && (num_addr == '0);
      if (start_run) begin
        rem_q      <= num_addr;
        sel_q      <= buf_sel;
        addr_cnt_q <= '0;
        grp_cnt_q  <= '0;
      end else if (issue) begin
        if (grp_last) begin
          grp_cnt_q  <= '0;
          addr_cnt_q <= addr_cnt_q + 1'b1;
          rem_q      <= rem_q - 1'b1;
        end else begin
          grp_cnt_q <= grp_cnt_q + 1'b1;
        end
      end
      req_vld_q  <= issue;
      req_last_q <= issue && last_req;
      en_q       <= issue ? grp_to_en(grp_cnt_q) : 3'd0;
      if (issue) req_addr_q <= addr_cnt_q;
      tag_vld_q[0]  <= req_vld_q;
      tag_last_q[0] <= req_last_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
    end
  end

  assign bs_out_buf_wb_en   = en_q;
  assign bs_out_buf_wb_addr = {BS_COLS{req_addr_q}};
  assign bs_out_buf_wb_sel  = sel_q;

  assign fifo_push       = tag_vld_q[RD_LAT-1];
  assign fifo_wdata.last = tag_last_q[RD_LAT-1];
  assign fifo_wdata.data = bs_out_wb_data;
  assign fifo_pop        = m_axis_tvalid && m_axis_tready;
  assign last_pop        = fifo_pop && fifo_rdata.last;

  bs_wb_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(wb_entry_t))
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .wdata(fifo_wdata),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // Head is gated so the stream reads as zero while nothing is valid.
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = m_axis_tvalid ? fifo_rdata.data : '0;
  assign m_axis_tlast  = m_axis_tvalid && fifo_rdata.last;

`ifdef BS_WB_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (m_axis_tvalid && !m_axis_tready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign wb_stall_cnt = stall_q;
`else
  assign wb_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_bs_out_wb_stream.sv
// Scoreboard bench for bs_out_wb_stream: a small core model answers read
// requests, stimulus queues expected beats, a monitor checks the stream.
module tb_bs_out_wb_stream;
  import bs_wb_pkg::*;

  localparam int COLS = 32;
  localparam int DW   = 9;
  localparam int FD   = 4;
  localparam int NG   = COLS / 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [DW:0]         num_addr = '0;
  logic                buf_sel = 1'b0;
  logic                busy, done;
  logic [2:0]          bs_out_buf_wb_en;
  logic [COLS*DW-1:0]  bs_out_buf_wb_addr;
  logic                bs_out_buf_wb_sel;
  logic [63:0]         bs_out_wb_data = '0;
  logic [63:0]         m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready = 1'b0;
  logic                m_axis_tlast;
  logic [31:0]         wb_stall_cnt;

  bs_out_wb_stream #(
    .BS_COLS(COLS),
    .BS_OUT_BUF_DEPTH(DW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .num_addr          (num_addr),
    .buf_sel           (buf_sel),
    .busy              (busy),
    .done              (done),
    .bs_out_buf_wb_en  (bs_out_buf_wb_en),
    .bs_out_buf_wb_addr(bs_out_buf_wb_addr),
    .bs_out_buf_wb_sel (bs_out_buf_wb_sel),
    .bs_out_wb_data    (bs_out_wb_data),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .wb_stall_cnt      (wb_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int a, input int g, input logic s);
    return {8'hC0, 7'd0, s, 16'(a), 16'(g), 16'hBEEF};
  endfunction

  // Core model: buffer read register then output register.
  logic [63:0] core_s1 = '0;
  always @(posedge clk) begin
    if (bs_out_buf_wb_en != 3'd0)
      core_s1 <= pat(int'(bs_out_buf_wb_addr[DW-1:0]), int'(bs_out_buf_wb_en) - 1, bs_out_buf_wb_sel);
    bs_out_wb_data <= core_s1;
  end

  int          checks = 0, errors = 0;
  logic [64:0] exp_q[$];
  logic        exp_sel = 1'b0;
  int          zero_starts = 0, zero_seen = 0;
  int          beats = 0, req_cnt = 0, stall_seen = 0, max_out = 0;
  int          beat_base = 0, req_base = 0, stall_base = 0;
  logic        done_exp = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
  logic [63:0] prev_data = '0;
  int          rdy_mode = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [64:0] e;
    logic        bad;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        done_exp   = 1'b0;
        req_cnt    = 0;
        beats      = 0;
        zero_seen  = zero_starts;
      end else begin
        if (done === 1'b1 || done_exp) chk("done_pulse", {64'd0, done}, {64'd0, done_exp});
        done_exp = 1'b0;
        if (zero_seen != zero_starts) begin
          done_exp  = 1'b1;
          zero_seen = zero_starts;
        end
        if (bs_out_buf_wb_en != 3'd0) begin
          req_cnt++;
          bad = 1'b0;
          for (int c = 1; c < COLS; c++)
            if (bs_out_buf_wb_addr[c*DW +: DW] !== bs_out_buf_wb_addr[DW-1:0]) bad = 1'b1;
          chk("req_cols_equal", {64'd0, bad}, 65'd0);
          chk("req_sel", {64'd0, bs_out_buf_wb_sel}, {64'd0, exp_sel});
          if (int'(bs_out_buf_wb_en) > NG) chk("req_en_range", {62'd0, bs_out_buf_wb_en}, 65'(NG));
        end
        if (req_cnt - beats > max_out) max_out = req_cnt - beats;
        if (prev_stall) begin
          chk("stall_valid", {64'd0, m_axis_tvalid}, 65'd1);
          chk("stall_data", {prev_last, prev_data}, {m_axis_tlast, m_axis_tdata});
        end
        if (m_axis_tvalid && !m_axis_tready) stall_seen++;
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {m_axis_tlast, m_axis_tdata}, 65'd0);
            errors += (m_axis_tlast == 1'b0 && m_axis_tdata == '0) ? 1 : 0;
          end else begin
            e = exp_q.pop_front();
            chk("beat", {m_axis_tlast, m_axis_tdata}, e);
          end
          beats++;
          if (m_axis_tlast) done_exp = 1'b1;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'b0;
      endcase
    end
  endtask

  task automatic do_start(input int n, input logic s, input bit accept);
    @(posedge clk);
    #1;
    start    = 1'b1;
    num_addr = (DW+1)'(n);
    buf_sel  = s;
    if (accept) begin
      beat_base  = beats;
      req_base   = req_cnt;
      stall_base = stall_seen;
      exp_sel    = s;
      if (n == 0) zero_starts++;
      for (int a = 0; a < n; a++)
        for (int g = 0; g < NG; g++)
          exp_q.push_back({(a == n - 1) && (g == NG - 1), pat(a, g, s)});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_timeout"}, {64'd0, cyc >= 600}, 65'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_tests();
    int cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", {64'd0, m_axis_tvalid}, 65'd0);
    chk("rst_tdata", {1'b0, m_axis_tdata}, 65'd0);
    chk("rst_busy_done", {63'd0, busy, done}, 65'd0);
    chk("rst_req", {61'd0, bs_out_buf_wb_sel, bs_out_buf_wb_en}, 65'd0);
    chk("rst_addr_zero", {64'd0, bs_out_buf_wb_addr == '0}, 65'd1);
    chk("rst_stall", {33'd0, wb_stall_cnt}, 65'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full-rate drain from bank 1.
    rdy_mode = 0;
    do_start(2, 1'b1, 1'b1);
    @(negedge clk);
    chk("t1_busy", {64'd0, busy}, 65'd1);
    wait_drain("t1");
    chk("t1_beats", 65'(beats - beat_base), 65'd8);
    chk("t1_reqs", 65'(req_cnt - req_base), 65'd8);
    chk("t1_busy_after", {64'd0, busy}, 65'd0);

    // Toggling backpressure.
    rdy_mode = 1;
    do_start(3, 1'b0, 1'b1);
    wait_drain("t2");
    chk("t2_beats", 65'(beats - beat_base), 65'd12);
    chk("t2_credit", {64'd0, max_out <= FD}, 65'd1);
`ifdef BS_WB_PERF_EN
    chk("t2_stall_cnt", {33'd0, wb_stall_cnt}, 65'(stall_seen - stall_base));
`else
    chk("t2_stall_cnt", {33'd0, wb_stall_cnt}, 65'd0);
`endif

    // Held-off consumer: credit caps issue at FIFO depth.
    for (int n = 1; n <= 2; n++) begin
      rdy_mode = 2;
      do_start(n, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      chk("t3_reqs_held", 65'(req_cnt - req_base), 65'd4);
      chk("t3_tvalid_held", {64'd0, m_axis_tvalid}, 65'd1);
      rdy_mode = 0;
      wait_drain("t3");
      chk("t3_beats", 65'(beats - beat_base), 65'(4 * n));
    end
    chk("t3_credit", {64'd0, max_out <= FD}, 65'd1);

    // Zero-length start.
    do_start(0, 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("t4_no_tvalid", {63'd0, m_axis_tvalid, busy}, 65'd0);
    end

    // Start while busy is ignored.
    rdy_mode = 1;
    do_start(2, 1'b1, 1'b1);
    do_start(3, 1'b0, 1'b0);
    wait_drain("t5");
    repeat (10) @(negedge clk);
    chk("t5_beats", 65'(beats - beat_base), 65'd8);
    chk("t5_reqs", 65'(req_cnt - req_base), 65'd8);

    // Reset mid-drain after beat 3, then a clean restart.
    rdy_mode = 1;
    do_start(2, 1'b0, 1'b1);
    cyc = 0;
    while ((beats - beat_base) < 3 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("t6_reach_beat3", {64'd0, cyc >= 200}, 65'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_tvalid_rst", {64'd0, m_axis_tvalid}, 65'd0);
    chk("t6_busy_rst", {64'd0, busy}, 65'd0);
    repeat (6) begin
      @(negedge clk);
      chk("t6_quiet", {62'd0, m_axis_tvalid, busy, done}, 65'd0);
    end
    rdy_mode = 0;
    do_start(2, 1'b0, 1'b1);
    wait_drain("t6");
    chk("t6_beats", 65'(beats - beat_base), 65'd8);
  endtask

  initial begin
    fork
      monitor();
      ready_drv();
      run_tests();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
